// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_ctrl_if
// Description : M-stage pipeline <-> CP0 exception controller signal bundle.
// Revision    : 1.0
// ============================================================================
interface cp0_exc_ctrl_if;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        we;
  logic        eret;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exccode_m;
  logic [5:0]  hwint;
  logic [31:0] rd_data;
  logic [31:0] epc;
  logic [31:0] handler_pc;
  logic        irq;
  logic        exl;

  modport master (
    output rd_addr, wr_addr, wr_data, we, eret, pc_m, bd_m, exccode_m, hwint,
    input  rd_data, epc, handler_pc, irq, exl
  );

  modport slave (
    input  rd_addr, wr_addr, wr_data, we, eret, pc_m, bd_m, exccode_m, hwint,
    output rd_data, epc, handler_pc, irq, exl
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_ctrl
// Description : CP0 exception/interrupt controller (SR, Cause, EPC, PRId).
// Revision    : 1.0
// ============================================================================
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID       = 32'h2000_0906,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  wire logic      clk,
  input  wire logic      reset,
  cp0_exc_ctrl_if.slave  bus
);

  localparam logic [4:0] c_addr_sr    = 5'd12;
  localparam logic [4:0] c_addr_cause = 5'd13;
  localparam logic [4:0] c_addr_epc   = 5'd14;
  localparam logic [4:0] c_addr_prid  = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:2] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_irq;
  logic [31:2] w_epc_entry;
  logic [31:0] w_rd_data;

  // A bubble (pc_m == 0) has no restart address, so interrupts wait for a real instruction.
  assign w_int_req = (|(bus.hwint & r_im)) & r_ie & ~r_exl & (bus.pc_m != 32'd0);
  assign w_exc_req = (bus.exccode_m != 5'd0) & ~r_exl;
  assign w_irq     = w_int_req | w_exc_req;

  // Word-address arithmetic: (pc - 4) >> 2 == (pc >> 2) - 1, modulo 2^30.
  assign w_epc_entry = bus.pc_m[31:2] - {29'd0, bus.bd_m};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 30'd0;
    end else begin
      r_ip <= bus.hwint;
      if (w_irq) begin
        r_exl     <= 1'b1;
        r_bd      <= bus.bd_m;
        r_exccode <= w_int_req ? 5'd0 : bus.exccode_m;
        r_epc     <= w_epc_entry;
      end else begin
        if (bus.we && bus.wr_addr == c_addr_sr) begin
          r_im  <= bus.wr_data[15:10];
          r_exl <= bus.wr_data[1];
          r_ie  <= bus.wr_data[0];
        end
        if (bus.we && bus.wr_addr == c_addr_epc) begin
          r_epc <= bus.wr_data[31:2];
        end
        // Placed after the SR write so eret's EXL clear wins over the mtc0 value.
        if (bus.eret) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_rd_data = 32'd0;
    case (bus.rd_addr)
      c_addr_sr:    w_rd_data = {16'd0, r_im, 8'd0, r_exl, r_ie};
      c_addr_cause: w_rd_data = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
      c_addr_epc:   w_rd_data = {r_epc, 2'b00};
      c_addr_prid:  w_rd_data = PRID;
      default:      w_rd_data = 32'd0;
    endcase
  end

  assign bus.rd_data    = w_rd_data;
  assign bus.epc        = {r_epc, 2'b00};
  assign bus.handler_pc = HANDLER_PC;
  assign bus.irq        = w_irq;
  assign bus.exl        = r_exl;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_exc_ctrl
// Description : Directed vector table plus randomized run against a CP0 model.
// Revision    : 1.0
// ============================================================================
module tb_cp0_exc_ctrl;

  localparam logic [31:0] c_prid    = 32'h2000_0906;
  localparam logic [31:0] c_handler = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl #(.PRID(c_prid), .HANDLER_PC(c_handler)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we;
    logic        eret;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hwint;
    logic        exp_irq;
    logic [31:0] exp_rd;
    logic        exp_exl;
  } vec_t;

  vec_t vecs[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: architectural register words.
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic m_int();
    return ((bus.hwint & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1] && (bus.pc_m != 32'd0);
  endfunction

  function automatic logic m_irq();
    return m_int() || ((bus.exccode_m != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return c_prid;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_update();
    logic take, intr;
    logic [31:0] ret;
    take = m_irq();
    intr = m_int();
    if (!reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = bus.hwint;
      if (take) begin
        m_sr[1]       = 1'b1;
        m_cause[31]   = bus.bd_m;
        m_cause[6:2]  = intr ? 5'd0 : bus.exccode_m;
        ret           = bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m;
        m_epc         = ret & 32'hFFFF_FFFC;
      end else begin
        if (bus.we && bus.wr_addr == 5'd12) m_sr  = bus.wr_data & 32'h0000_FC03;
        if (bus.we && bus.wr_addr == 5'd14) m_epc = bus.wr_data & 32'hFFFF_FFFC;
        if (bus.eret) m_sr[1] = 1'b0;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst_n;
    bus.rd_addr   = v.rd_addr;
    bus.wr_addr   = v.wr_addr;
    bus.wr_data   = v.wr_data;
    bus.we        = v.we;
    bus.eret      = v.eret;
    bus.pc_m      = v.pc;
    bus.bd_m      = v.bd;
    bus.exccode_m = v.exc;
    bus.hwint     = v.hwint;
  endtask

  task automatic model_checks();
    chk("irq_model",     {31'd0, bus.irq}, {31'd0, m_irq()});
    chk("rd_data_model", bus.rd_data, m_read(bus.rd_addr));
    chk("epc_model",     bus.epc, m_epc);
    chk("exl_model",     {31'd0, bus.exl}, {31'd0, m_sr[1]});
    chk("handler_pc",    bus.handler_pc, c_handler);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic add(input logic r, input logic [4:0] ra, input logic [4:0] wa,
                     input logic [31:0] wd, input logic we, input logic er,
                     input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                     input logic [5:0] hw, input logic ei, input logic [31:0] erd,
                     input logic ex);
    vec_t v;
    v.rst_n = r; v.rd_addr = ra; v.wr_addr = wa; v.wr_data = wd; v.we = we;
    v.eret = er; v.pc = pc; v.bd = bd; v.exc = exc; v.hwint = hw;
    v.exp_irq = ei; v.exp_rd = erd; v.exp_exl = ex;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    // rst rd  wa  wdata          we er pc            bd exc    hwint      irq rd             exl
    add(1, 12, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0,         0);
    add(1, 13, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0,         0);
    add(1, 14, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0,         0);
    add(1, 15, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h2000_0906, 0);
    add(1, 12, 12, 32'h0000_FC01, 1, 0, 0,           0, 0,     6'b000000, 0, 32'h0,         0);
    add(1, 12, 0, 0,             0, 0, 32'h3010,     0, 0,     6'b000100, 1, 32'h0000_FC01, 0);
    add(1, 13, 0, 0,             0, 0, 0,            0, 0,     6'b000100, 0, 32'h0000_1000, 1);
    add(1, 14, 0, 0,             0, 0, 0,            0, 0,     6'b000100, 0, 32'h0000_3010, 1);
    add(1, 12, 0, 0,             0, 0, 0,            0, 0,     6'b000100, 0, 32'h0000_FC03, 1);
    add(1, 12, 0, 0,             0, 1, 0,            0, 0,     6'b000000, 0, 32'h0000_FC03, 1);
    add(1, 12, 0, 0,             0, 0, 32'h3024,     1, 5'd12, 6'b000000, 1, 32'h0000_FC01, 0);
    add(1, 13, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h8000_0030, 1);
    add(1, 14, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0000_3020, 1);
    add(1, 12, 0, 0,             0, 1, 0,            0, 0,     6'b000000, 0, 32'h0000_FC03, 1);
    add(1, 12, 0, 0,             0, 0, 32'h3024,     1, 5'd12, 6'b000001, 1, 32'h0000_FC01, 0);
    add(1, 13, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h8000_0400, 1);
    add(1, 14, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0000_3020, 1);
    add(1, 12, 0, 0,             0, 1, 0,            0, 0,     6'b000000, 0, 32'h0000_FC03, 1);
    add(1, 13, 0, 0,             0, 0, 0,            0, 0,     6'b000010, 0, 32'h8000_0000, 0);
    add(1, 13, 0, 0,             0, 0, 0,            0, 0,     6'b000010, 0, 32'h8000_0800, 0);
    add(1, 13, 0, 0,             0, 0, 32'h3040,     0, 0,     6'b000010, 1, 32'h8000_0800, 0);
    add(1, 14, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0000_3040, 1);
    add(1, 13, 0, 0,             0, 0, 32'h3050,     0, 5'd10, 6'b000000, 0, 32'h0000_0000, 1);
    add(1, 12, 0, 0,             0, 1, 0,            0, 0,     6'b000000, 0, 32'h0000_FC03, 1);
    add(1, 12, 0, 0,             0, 0, 32'h3050,     0, 5'd10, 6'b000000, 1, 32'h0000_FC01, 0);
    add(1, 13, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0000_0028, 1);
    add(1, 14, 13, 32'hFFFF_FFFF, 1, 0, 0,           0, 0,     6'b000000, 0, 32'h0000_3050, 1);
    add(1, 13, 12, 32'hFFFF_FFFF, 1, 1, 0,           0, 0,     6'b000000, 0, 32'h0000_0028, 1);
    add(1, 12, 14, 32'h1234_5677, 1, 0, 0,           0, 0,     6'b000000, 0, 32'h0000_FC01, 0);
    add(1, 14, 14, 32'h0000_0000, 1, 0, 32'h3060,    0, 5'd4,  6'b000000, 1, 32'h1234_5674, 0);
    add(1, 14, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0000_3060, 1);
    add(1, 16, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0,         1);
    add(0, 12, 12, 32'h0000_FC01, 1, 0, 32'h3070,    0, 5'd4,  6'b111111, 0, 32'h0000_FC03, 1);
    add(1, 12, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0,         0);
    add(1, 13, 0, 0,             0, 0, 0,            0, 0,     6'b000000, 0, 32'h0,         0);

    m_sr = 0; m_cause = 0; m_epc = 0;
    v = vecs[0];
    v.rst_n = 1'b0;
    drive(v);
    @(negedge clk);
    repeat (2) finish_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].exp_irq});
      chk($sformatf("vec%0d_rd",  i), bus.rd_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_exl", i), {31'd0, bus.exl}, {31'd0, vecs[i].exp_exl});
      model_checks();
      finish_cycle();
    end

    for (int i = 0; i < 600; i++) begin
      logic [4:0] waddrs [5];
      waddrs[0] = 5'd12; waddrs[1] = 5'd13; waddrs[2] = 5'd14; waddrs[3] = 5'd15;
      waddrs[4] = 5'($urandom);
      reset         = ($urandom_range(0, 59) != 0);
      bus.rd_addr   = 5'($urandom_range(10, 17));
      bus.wr_addr   = waddrs[$urandom_range(0, 4)];
      bus.wr_data   = $urandom;
      bus.we        = ($urandom_range(0, 3) == 0);
      bus.eret      = ($urandom_range(0, 5) == 0);
      bus.pc_m      = ($urandom_range(0, 3) == 0) ? 32'd0 :
                      (($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      bus.bd_m      = 1'($urandom);
      bus.exccode_m = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      bus.hwint     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      #1;
      model_checks();
      finish_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
